// File: rtl/cpu_op_sequencer.sv
// Program-table driven issuer for the 8-bit CPU top: issues {opcode,A,B} with a cpu_wr strobe,
// waits LATENCY cycles, and captures Y into a result buffer. Optional self-check: SEQ_CHECK_EN.
module cpu_op_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_opcode,
  input  logic [DATA_WIDTH-1:0] prog_a,
  input  logic [DATA_WIDTH-1:0] prog_b,
  input  logic [DATA_WIDTH-1:0] prog_exp,
  input  logic [ADDR_WIDTH:0]   prog_len,
  input  logic                  start,
  output logic                  cpu_wr,
  output logic [DATA_WIDTH-1:0] cpu_a,
  output logic [DATA_WIDTH-1:0] cpu_b,
  output logic [DATA_WIDTH-1:0] cpu_opcode,
  input  logic [DATA_WIDTH-1:0] cpu_y,
  input  logic [ADDR_WIDTH-1:0] res_addr,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   mismatch_cnt,
  output logic [ADDR_WIDTH-1:0] first_fail
);

  localparam int                DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_V = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_V   = (ADDR_WIDTH+1)'(1);
  localparam logic [3:0]        WAIT_INIT = 4'(LATENCY - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [3:0]            wait_q, wait_d;
  logic                  start_acc;

  logic [DATA_WIDTH-1:0] op_mem  [DEPTH];
  logic [DATA_WIDTH-1:0] a_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] b_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] res_mem [DEPTH];

  logic [DATA_WIDTH-1:0] cpu_a_q, cpu_b_q, cpu_op_q, res_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    wait_d    = wait_q;
    start_acc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          idx_d     = '0;
          len_d     = (prog_len > DEPTH_V) ? DEPTH_V : prog_len;
          state_d   = (prog_len == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        wait_d  = WAIT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == 4'd0) state_d = S_CAPTURE;
        else                wait_d  = wait_q - 4'd1;
      end
      S_CAPTURE: begin
        if (idx_q == len_q - ONE_V) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + ONE_V;
          state_d = S_ISSUE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy   = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_CAPTURE);
  assign done   = (state_q == S_DONE);
  assign cpu_wr = (state_q == S_ISSUE);

  // Program table: writes are dropped while a run owns the table.
  always_ff @(posedge clk) begin
    if (prog_we && !busy) begin
      op_mem[prog_addr] <= prog_opcode;
      a_mem[prog_addr]  <= prog_a;
      b_mem[prog_addr]  <= prog_b;
    end
  end

  // Operands are loaded on the edge entering ISSUE so they are stable while cpu_wr is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_a_q  <= '0;
      cpu_b_q  <= '0;
      cpu_op_q <= '0;
    end else if (state_d == S_ISSUE) begin
      cpu_a_q  <= a_mem[idx_d[ADDR_WIDTH-1:0]];
      cpu_b_q  <= b_mem[idx_d[ADDR_WIDTH-1:0]];
      cpu_op_q <= op_mem[idx_d[ADDR_WIDTH-1:0]];
    end
  end

  assign cpu_a      = cpu_a_q;
  assign cpu_b      = cpu_b_q;
  assign cpu_opcode = cpu_op_q;

  always_ff @(posedge clk) begin
    if (state_q == S_CAPTURE) res_mem[idx_q[ADDR_WIDTH-1:0]] <= cpu_y;
  end

  // Read-before-write: a same-cycle capture to res_addr is seen on the following read.
  always_ff @(posedge clk) begin
    if (reset) res_data_q <= '0;
    else       res_data_q <= res_mem[res_addr];
  end

  assign res_data = res_data_q;

`ifdef SEQ_CHECK_EN
  logic [DATA_WIDTH-1:0] exp_mem [DEPTH];
  logic [ADDR_WIDTH:0]   mis_q;
  logic [ADDR_WIDTH-1:0] ff_q;

  function automatic logic [ADDR_WIDTH:0] sat_inc(input logic [ADDR_WIDTH:0] v);
    return (&v) ? v : v + ONE_V;
  endfunction

  always_ff @(posedge clk) begin
    if (prog_we && !busy) exp_mem[prog_addr] <= prog_exp;
  end

  always_ff @(posedge clk) begin
    if (reset || start_acc) begin
      mis_q <= '0;
      ff_q  <= '0;
    end else if (state_q == S_CAPTURE && cpu_y != exp_mem[idx_q[ADDR_WIDTH-1:0]]) begin
      if (mis_q == '0) ff_q <= idx_q[ADDR_WIDTH-1:0];
      mis_q <= sat_inc(mis_q);
    end
  end

  assign mismatch_cnt = mis_q;
  assign first_fail   = ff_q;
`else
  logic unused_exp;
  assign unused_exp   = ^{prog_exp, start_acc};
  assign mismatch_cnt = '0;
  assign first_fail   = '0;
`endif

endmodule

// File: tb/tb_cpu_op_sequencer.sv
// Directed bench for cpu_op_sequencer with a 1-cycle-latency CPU model (add/sub/and/or).
module tb_cpu_op_sequencer;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_opcode, prog_a, prog_b, prog_exp;
  logic [AW:0]   prog_len;
  logic          start;
  logic          cpu_wr;
  logic [DW-1:0] cpu_a, cpu_b, cpu_opcode, cpu_y;
  logic [AW-1:0] res_addr;
  logic [DW-1:0] res_data;
  logic          busy, done;
  logic [AW:0]   mismatch_cnt;
  logic [AW-1:0] first_fail;

  always #5 clk = ~clk;

  cpu_op_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(1)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_opcode(prog_opcode), .prog_a(prog_a), .prog_b(prog_b), .prog_exp(prog_exp),
    .prog_len(prog_len), .start(start), .cpu_wr(cpu_wr), .cpu_a(cpu_a), .cpu_b(cpu_b),
    .cpu_opcode(cpu_opcode), .cpu_y(cpu_y), .res_addr(res_addr), .res_data(res_data),
    .busy(busy), .done(done), .mismatch_cnt(mismatch_cnt), .first_fail(first_fail)
  );

  function automatic logic [DW-1:0] cpu_model(input logic [DW-1:0] op, a, b);
    case (op)
      8'h00:   return a + b;
      8'h02:   return a - b;
      8'h08:   return a & b;
      8'h09:   return a | b;
      default: return '0;
    endcase
  endfunction

  logic [DW-1:0] y_model = '0;
  assign cpu_y = y_model;
  always @(negedge clk) if (cpu_wr) y_model <= cpu_model(cpu_opcode, cpu_a, cpu_b);

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog_write(input logic [AW-1:0] addr, input logic [DW-1:0] op, a, b, e);
    prog_we = 1'b1; prog_addr = addr; prog_opcode = op; prog_a = a; prog_b = b; prog_exp = e;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic read_res(input logic [AW-1:0] addr, output logic [DW-1:0] data);
    res_addr = addr;
    tick();
    data = res_data;
  endtask

  logic [63:0]   wr_mask, done_mask;
  int            busy_cnt;
  logic [DW-1:0] wr_ops[$];
  logic [DW-1:0] rd_log[64];

  task automatic run(input logic [AW:0] len, input int ncyc, input bit inject);
    wr_mask = '0; done_mask = '0; busy_cnt = 0; wr_ops.delete();
    prog_len = len; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (cpu_wr) begin wr_mask[c] = 1'b1; wr_ops.push_back(cpu_opcode); end
      if (done) done_mask[c] = 1'b1;
      if (busy) busy_cnt++;
      rd_log[c] = res_data;
      if (inject && c == 4) begin
        prog_we = 1'b1; prog_addr = 1; prog_opcode = 8'h09; prog_a = 8'd8; prog_b = 8'd4;
        start = 1'b1;
      end
      tick();
      prog_we = 1'b0; start = 1'b0;
    end
  endtask

  logic [DW-1:0] rd;
  logic [63:0]   exp_mask;
  int            done_seen;

  initial begin
    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_opcode = '0; prog_a = '0; prog_b = '0;
    prog_exp = '0; prog_len = '0; start = 1'b0; res_addr = '0;

    // T1 reset
    tick(); tick();
    check("rst_cpu_wr", cpu_wr, 0);
    check("rst_cpu_a", cpu_a, 0);
    check("rst_cpu_b", cpu_b, 0);
    check("rst_cpu_op", cpu_opcode, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_res_data", res_data, 0);
    check("rst_mismatch", mismatch_cnt, 0);
    reset = 1'b0;
    tick();

    // T2 basic run with T4 busy-guard injection at cycle 4
    prog_write(0, 8'h00, 8'd8, 8'd4, 8'h0C);
    prog_write(1, 8'h02, 8'd8, 8'd4, 8'h04);
    prog_write(2, 8'h08, 8'd8, 8'd4, 8'h00);
    run(3, 14, 1'b1);
    check("t2_wr_cycles", wr_mask, 64'h92);
    check("t2_busy_cycles", busy_cnt, 9);
    check("t2_done_cycle", done_mask, 64'h400);
    check("t2_op0", wr_ops.size() > 0 ? wr_ops[0] : 8'hFF, 8'h00);
    check("t2_op1", wr_ops.size() > 1 ? wr_ops[1] : 8'hFF, 8'h02);
    check("t2_op2", wr_ops.size() > 2 ? wr_ops[2] : 8'hFF, 8'h08);
    check("t2_mismatch", mismatch_cnt, 0);
    read_res(0, rd); check("t2_res0", rd, 8'h0C);
    read_res(1, rd); check("t2_res1", rd, 8'h04);
    read_res(2, rd); check("t2_res2", rd, 8'h00);

    // T4 re-run: entry 1 must be unchanged and exactly 3 issues
    run(3, 14, 1'b0);
    check("t4_wr_count", $countones(wr_mask), 3);
    check("t4_op1", wr_ops.size() > 1 ? wr_ops[1] : 8'hFF, 8'h02);
    check("t4_done_cycle", done_mask, 64'h400);
    read_res(1, rd); check("t4_res1", rd, 8'h04);

    // T3 len=0
    prog_len = 0; start = 1'b1;
    tick();
    start = 1'b0;
    check("t3_done", done, 1);
    check("t3_wr", cpu_wr, 0);
    check("t3_busy", busy, 0);
    tick();
    check("t3_done_clear", done, 0);
    check("t3_wr_after", cpu_wr, 0);

    // T5 reset during op 1's WAIT (cycle 5 after start)
    prog_len = 3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("t5_busy_before", busy, 1);
    reset = 1'b1;
    tick();
    check("t5_cpu_wr", cpu_wr, 0);
    check("t5_cpu_a", cpu_a, 0);
    check("t5_cpu_b", cpu_b, 0);
    check("t5_cpu_op", cpu_opcode, 0);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_res_data", res_data, 0);
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) done_seen++;
      tick();
    end
    check("t5_no_done", done_seen, 0);
    read_res(0, rd); check("t5_res0_kept", rd, 8'h0C);
    run(3, 14, 1'b0);
    check("t5_rerun_done", done_mask, 64'h400);
    check("t5_rerun_wr", wr_mask, 64'h92);
    read_res(2, rd); check("t5_rerun_res2", rd, 8'h00);

`ifdef SEQ_CHECK_EN
    // T6 expected-value checking
    prog_write(1, 8'h02, 8'd8, 8'd4, 8'h05);
    run(3, 14, 1'b0);
    check("t6_mismatch_cnt", mismatch_cnt, 1);
    check("t6_first_fail", first_fail, 1);
    check("t6_done", done_mask, 64'h400);
`endif

    // Full depth: prog_len above table depth clamps to 16 entries
    for (int i = 0; i < 16; i++) prog_write(AW'(i), 8'h00, 8'(i), 8'd1, 8'(i + 1));
    res_addr = 0;
    tick();
    exp_mask = '0;
    for (int k = 0; k < 16; k++) exp_mask[1 + 3 * k] = 1'b1;
    run(31, 52, 1'b0);
    check("full_wr_count", $countones(wr_mask), 16);
    check("full_wr_cycles", wr_mask, exp_mask);
    check("full_busy_cycles", busy_cnt, 48);
    check("full_done_cycle", done_mask, 64'h1 << 49);
    check("full_rbw_old", rd_log[4], 8'h0C);
    check("full_rbw_new", rd_log[5], 8'h01);
    check("full_mismatch", mismatch_cnt, 0);
    check("full_first_fail", first_fail, 0);
    read_res(15, rd); check("full_res15", rd, 8'h10);
    read_res(7, rd);  check("full_res7", rd, 8'h08);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
